// File: rtl/load_use_scoreboard.sv
// ---------------------------------------------------------------------------
// load_use_scoreboard
//
// Sits beside the decode stage of a 5-stage MIPS pipeline. It decodes the
// D-stage instruction into load/store class, access size and signedness,
// remembers the destination registers of loads that recently left D, and
// raises a load-use stall when the D instruction reads one of them before
// the loaded value can be forwarded. A saturating counter records the
// number of stalled cycles for performance statistics.
//
// Parameters:
//   LOAD_LATENCY    cycles a dependent instruction must hold in D after the
//                   producing load left D (1 = forwarding from W into E);
//                   legal range 1..4
//   REG_ADDR_WIDTH  register index width
//   COUNT_WIDTH     width of stall_count (at least 2)
//
// Ports:
//   clk              clock, all state on the rising edge
//   reset            asynchronous active-low reset
//   instruction_d    instruction currently in D
//   valid_d          instruction_d is real (0 = bubble)
//   flush            squash all tracking and the D instruction this cycle
//   stall            hold D and F this cycle; E receives a bubble
//   is_load          D instruction is lb/lbu/lh/lhu/lw
//   is_store         D instruction is sb/sh/sw
//   access_size      0 byte, 1 half, 2 word; 0 when not a memory op
//   access_unsigned  1 for lbu/lhu only
//   stall_count      saturating count of cycles with stall = 1
// ---------------------------------------------------------------------------
module load_use_scoreboard #(
    parameter int LOAD_LATENCY   = 1,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instruction_d,
    input  logic                   valid_d,
    input  logic                   flush,
    output logic                   stall,
    output logic                   is_load,
    output logic                   is_store,
    output logic [1:0]             access_size,
    output logic                   access_unsigned,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    // Primary opcodes this block cares about.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO  = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0]    COUNT_MAX = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0]    COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    // Instruction fields. The register indices sit at the usual MIPS
    // positions; REG_ADDR_WIDTH only sets how many bits are compared.
    logic [5:0]                opcode_s;
    logic [REG_ADDR_WIDTH-1:0] rs_s;
    logic [REG_ADDR_WIDTH-1:0] rt_s;
    logic                      unused_bits_s;

    assign opcode_s      = instruction_d[31:26];
    assign rs_s          = instruction_d[21 +: REG_ADDR_WIDTH];
    assign rt_s          = instruction_d[16 +: REG_ADDR_WIDTH];
    assign unused_bits_s = ^instruction_d[15:0];

    // Ungated decode results.
    logic       dec_load_s;
    logic       dec_store_s;
    logic [1:0] dec_size_s;
    logic       dec_unsigned_s;
    logic       use_rs_s;
    logic       use_rt_s;

    // Tracker: bit/slot 0 is the youngest load.
    logic [LOAD_LATENCY-1:0]                     ent_v_r;
    logic [LOAD_LATENCY-1:0][REG_ADDR_WIDTH-1:0] ent_dst_r;

    logic                   hazard_s;
    logic                   insert_s;
    logic [COUNT_WIDTH-1:0] stall_count_r;

    // Memory-operation decode of the D opcode.
    always_comb begin
        dec_load_s     = 1'b0;
        dec_store_s    = 1'b0;
        dec_size_s     = SIZE_BYTE;
        dec_unsigned_s = 1'b0;
        case (opcode_s)
            OP_LB: begin
                dec_load_s = 1'b1;
            end
            OP_LBU: begin
                dec_load_s     = 1'b1;
                dec_unsigned_s = 1'b1;
            end
            OP_LH: begin
                dec_load_s = 1'b1;
                dec_size_s = SIZE_HALF;
            end
            OP_LHU: begin
                dec_load_s     = 1'b1;
                dec_size_s     = SIZE_HALF;
                dec_unsigned_s = 1'b1;
            end
            OP_LW: begin
                dec_load_s = 1'b1;
                dec_size_s = SIZE_WORD;
            end
            OP_SB: begin
                dec_store_s = 1'b1;
            end
            OP_SH: begin
                dec_store_s = 1'b1;
                dec_size_s  = SIZE_HALF;
            end
            OP_SW: begin
                dec_store_s = 1'b1;
                dec_size_s  = SIZE_WORD;
            end
            default: begin
                dec_load_s     = 1'b0;
                dec_store_s    = 1'b0;
                dec_size_s     = SIZE_BYTE;
                dec_unsigned_s = 1'b0;
            end
        endcase
    end

    // Which source fields the D instruction actually reads.
    always_comb begin
        use_rs_s = 1'b1;
        use_rt_s = 1'b0;
        case (opcode_s)
            OP_J, OP_JAL, OP_LUI: begin
                use_rs_s = 1'b0;
            end
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: begin
                use_rt_s = 1'b1;
            end
            default: begin
                use_rs_s = 1'b1;
                use_rt_s = 1'b0;
            end
        endcase
    end

    // Decode outputs qualified by valid_d; bubbles decode as nothing.
    always_comb begin
        is_load         = valid_d & dec_load_s;
        is_store        = valid_d & dec_store_s;
        access_size     = (valid_d & (dec_load_s | dec_store_s)) ? dec_size_s : SIZE_BYTE;
        access_unsigned = valid_d & dec_unsigned_s;
    end

    // Compare used sources against every valid in-flight load destination.
    // $0 is excluded explicitly even though it is never inserted.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < LOAD_LATENCY; i++) begin
            if (ent_v_r[i] &&
                ((use_rs_s && (rs_s != REG_ZERO) && (rs_s == ent_dst_r[i])) ||
                 (use_rt_s && (rt_s != REG_ZERO) && (rt_s == ent_dst_r[i])))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        hazard_s = hazard_s & valid_d;
    end

    // Flush wins over a stall; the reset term keeps stall low while the
    // tracker is being cleared asynchronously.
    assign stall = hazard_s & ~flush & reset;

    // A load is only recorded once it actually leaves D.
    assign insert_s = valid_d & dec_load_s & (rt_s != REG_ZERO) & ~stall & ~flush;

    // Tracker shift register: one slot per cycle of load latency; the
    // oldest slot falls off the end every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_v_r   <= {LOAD_LATENCY{1'b0}};
            ent_dst_r <= {LOAD_LATENCY{REG_ZERO}};
        end else if (flush) begin
            ent_v_r   <= {LOAD_LATENCY{1'b0}};
            ent_dst_r <= {LOAD_LATENCY{REG_ZERO}};
        end else begin
            for (int i = LOAD_LATENCY - 1; i > 0; i--) begin
                ent_v_r[i]   <= ent_v_r[i-1];
                ent_dst_r[i] <= ent_dst_r[i-1];
            end
            ent_v_r[0]   <= insert_s;
            ent_dst_r[0] <= insert_s ? rt_s : REG_ZERO;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_r <= {COUNT_WIDTH{1'b0}};
        end else if (stall && (stall_count_r != COUNT_MAX)) begin
            stall_count_r <= stall_count_r + COUNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_load_use_scoreboard
//
// Three instances share one stimulus stream:
//   a: LOAD_LATENCY = 1, COUNT_WIDTH = 16
//   b: LOAD_LATENCY = 3, COUNT_WIDTH = 16
//   c: LOAD_LATENCY = 1, COUNT_WIDTH = 2
// The reference model records, per register, the cycle in which the most
// recent load to it was accepted; a read of that register is a hazard
// while fewer than LOAD_LATENCY cycles have elapsed since.
// ---------------------------------------------------------------------------
module tb_load_use_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_d;
    logic        valid_d;
    logic        flush;

    logic        stall_a, is_load_a, is_store_a, uns_a;
    logic [1:0]  size_a;
    logic [15:0] cnt_a;
    logic        stall_b, is_load_b, is_store_b, uns_b;
    logic [1:0]  size_b;
    logic [15:0] cnt_b;
    logic        stall_c, is_load_c, is_store_c, uns_c;
    logic [1:0]  size_c;
    logic [1:0]  cnt_c;

    always #5 clk = ~clk;

    load_use_scoreboard #(.LOAD_LATENCY(1), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .instruction_d(instruction_d), .valid_d(valid_d), .flush(flush),
        .stall(stall_a), .is_load(is_load_a), .is_store(is_store_a), .access_size(size_a),
        .access_unsigned(uns_a), .stall_count(cnt_a));

    load_use_scoreboard #(.LOAD_LATENCY(3), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .instruction_d(instruction_d), .valid_d(valid_d), .flush(flush),
        .stall(stall_b), .is_load(is_load_b), .is_store(is_store_b), .access_size(size_b),
        .access_unsigned(uns_b), .stall_count(cnt_b));

    load_use_scoreboard #(.LOAD_LATENCY(1), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(2)) dut_c (
        .clk(clk), .reset(reset), .instruction_d(instruction_d), .valid_d(valid_d), .flush(flush),
        .stall(stall_c), .is_load(is_load_c), .is_store(is_store_c), .access_size(size_c),
        .access_unsigned(uns_c), .stall_count(cnt_c));

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state.
    int acc   [3][32];
    int cnt_m [3];
    int lat   [3] = '{1, 3, 1};
    int cmax  [3] = '{65535, 65535, 3};

    // Last values sampled by step(), for directed checks.
    logic       last_sa, last_sb, last_sc;
    logic       last_ld, last_st, last_uns;
    logic [1:0] last_sz;

    typedef struct {
        logic [31:0] ins;
        logic        v;
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic        uns;
    } dec_vec_t;

    dec_vec_t tbl [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 3; m++) begin
            cnt_m[m] = 0;
            for (int r = 0; r < 32; r++) acc[m][r] = -1000;
        end
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, input logic v,
                                       output logic ld, output logic st,
                                       output logic [1:0] sz, output logic uns);
        logic [5:0] op;
        op  = ins[31:26];
        ld  = v && (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25});
        st  = v && (op inside {6'h28, 6'h29, 6'h2B});
        sz  = (ld || st) ? ((op[1:0] == 2'b11) ? 2'd2 : op[1:0]) : 2'd0;
        uns = ld && op[2];
    endfunction

    function automatic logic ref_hazard(input int m, input logic [31:0] ins, input logic v, input int cy);
        logic [5:0] op;
        int rs, rt;
        logic use_rs, use_rt;
        op     = ins[31:26];
        rs     = int'(ins[25:21]);
        rt     = int'(ins[20:16]);
        use_rs = !(op inside {6'h02, 6'h03, 6'h0F});
        use_rt = op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
        return v && ((use_rs && rs != 0 && (cy - acc[m][rs]) < lat[m]) ||
                     (use_rt && rt != 0 && (cy - acc[m][rt]) < lat[m]));
    endfunction

    // One clock cycle: drive, check mid-cycle, advance the model at the edge.
    task automatic step(input logic [31:0] ins, input logic v, input logic fl);
        logic ld, st, uns;
        logic [1:0] sz;
        logic es [3];
        instruction_d = ins;
        valid_d       = v;
        flush         = fl;
        ref_decode(ins, v, ld, st, sz, uns);
        for (int m = 0; m < 3; m++) es[m] = ref_hazard(m, ins, v, cyc) && !fl;
        @(negedge clk);
        last_sa = stall_a; last_sb = stall_b; last_sc = stall_c;
        last_ld = is_load_a; last_st = is_store_a; last_sz = size_a; last_uns = uns_a;
        check("stall_lat1", stall_a, es[0]);
        check("stall_lat3", stall_b, es[1]);
        check("stall_cw2", stall_c, es[2]);
        check("is_load", is_load_a, ld);
        check("is_store", is_store_a, st);
        check("access_size", size_a, sz);
        check("access_unsigned", uns_a, uns);
        check("is_load_lat3", is_load_b, ld);
        check("count_lat1", cnt_a, cnt_m[0]);
        check("count_lat3", cnt_b, cnt_m[1]);
        check("count_cw2", cnt_c, cnt_m[2]);
        @(posedge clk);
        cyc++;
        for (int m = 0; m < 3; m++) begin
            if (es[m] && cnt_m[m] < cmax[m]) cnt_m[m]++;
            if (fl) begin
                for (int r = 0; r < 32; r++) acc[m][r] = -1000;
            end else if (ld && ins[20:16] != 5'd0 && !es[m]) begin
                acc[m][int'(ins[20:16])] = cyc;
            end
        end
        #1;
    endtask

    // Reset asserted away from clock edges, held across one edge.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b1;
    endtask

    localparam logic [31:0] LW8   = 32'h8D280000;
    localparam logic [31:0] ADD8  = 32'h010B5020;
    localparam logic [31:0] SW8   = 32'hAD280004;
    localparam logic [31:0] LW0   = 32'h8D200000;
    localparam logic [31:0] ADD0  = 32'h00005020;
    localparam logic [31:0] LUI8  = 32'h3C080001;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [14];
        logic [31:0] rins;

        tbl[0]  = '{32'h81280000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0}; // lb
        tbl[1]  = '{32'h91280000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1}; // lbu
        tbl[2]  = '{32'h85280000, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0}; // lh
        tbl[3]  = '{32'h95280000, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1}; // lhu
        tbl[4]  = '{32'h8D280000, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0}; // lw
        tbl[5]  = '{32'hA1280000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0}; // sb
        tbl[6]  = '{32'hA5280000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0}; // sh
        tbl[7]  = '{32'hAD280000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0}; // sw
        tbl[8]  = '{32'h00000000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}; // sll/nop
        tbl[9]  = '{32'h3C080001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}; // lui
        tbl[10] = '{32'h89280000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}; // lwl, not handled
        tbl[11] = '{32'h8D280000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}; // lw as bubble

        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                6'h00, 6'h04, 6'h05, 6'h02, 6'h0F, 6'h08};

        reset         = 1'b0;
        instruction_d = 32'h0;
        valid_d       = 1'b0;
        flush         = 1'b0;
        model_reset();

        // Reset state.
        #12;
        check("reset_stall", stall_a, 1'b0);
        check("reset_count", cnt_a, 16'd0);
        check("reset_count_cw2", cnt_c, 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Decode sweep.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].ins, tbl[i].v, 1'b0);
            check("tbl_is_load", last_ld, tbl[i].ld);
            check("tbl_is_store", last_st, tbl[i].st);
            check("tbl_size", last_sz, tbl[i].sz);
            check("tbl_unsigned", last_uns, tbl[i].uns);
        end

        // Load then consumer.
        do_reset();
        step(LW8, 1'b1, 1'b0);
        check("lu_no_self_stall", last_sa, 1'b0);
        step(ADD8, 1'b1, 1'b0);
        check("lu_stall1_lat1", last_sa, 1'b1);
        check("lu_stall1_lat3", last_sb, 1'b1);
        step(ADD8, 1'b1, 1'b0);
        check("lu_release_lat1", last_sa, 1'b0);
        check("lu_stall2_lat3", last_sb, 1'b1);
        step(ADD8, 1'b1, 1'b0);
        check("lu_stall3_lat3", last_sb, 1'b1);
        step(ADD8, 1'b1, 1'b0);
        check("lu_release_lat3", last_sb, 1'b0);
        check("lu_count_lat1", cnt_a, 16'd1);
        check("lu_count_lat3", cnt_b, 16'd3);

        // Store data dependency.
        do_reset();
        step(LW8, 1'b1, 1'b0);
        step(SW8, 1'b1, 1'b0);
        check("st_stall", last_sa, 1'b1);
        check("st_is_store", last_st, 1'b1);
        check("st_size", last_sz, 2'd2);
        check("st_unsigned", last_uns, 1'b0);
        step(SW8, 1'b1, 1'b0);
        check("st_release", last_sa, 1'b0);

        // No false hazards.
        do_reset();
        step(LW0, 1'b1, 1'b0);
        step(ADD0, 1'b1, 1'b0);
        check("r0_no_stall", last_sa, 1'b0);
        check("r0_no_stall_lat3", last_sb, 1'b0);
        step(LW8, 1'b1, 1'b0);
        step(LUI8, 1'b1, 1'b0);
        check("lui_no_stall", last_sa, 1'b0);
        check("lui_no_stall_lat3", last_sb, 1'b0);

        // Back-to-back loads to $8; stall lasts until the younger ages out.
        do_reset();
        step(LW8, 1'b1, 1'b0);
        step(LW8, 1'b1, 1'b0);
        step(ADD8, 1'b1, 1'b0);
        check("b2b_stall_lat1", last_sa, 1'b1);
        step(ADD8, 1'b1, 1'b0);
        check("b2b_release_lat1", last_sa, 1'b0);
        check("b2b_stall_lat3", last_sb, 1'b1);

        // Load whose base depends on a pending load: held, then inserted.
        do_reset();
        step(LW8, 1'b1, 1'b0);
        step(32'h8D090000, 1'b1, 1'b0); // lw $9,0($8)
        check("ldld_stall", last_sa, 1'b1);
        step(32'h8D090000, 1'b1, 1'b0);
        check("ldld_release", last_sa, 1'b0);
        step(32'h012B5020, 1'b1, 1'b0); // add $10,$9,$11
        check("ldld_inserted", last_sa, 1'b1);

        // Flush during the stalled cycle.
        do_reset();
        step(LW8, 1'b1, 1'b0);
        step(ADD8, 1'b1, 1'b1);
        check("flush_stall_lat1", last_sa, 1'b0);
        check("flush_stall_lat3", last_sb, 1'b0);
        step(ADD8, 1'b1, 1'b0);
        check("flush_empty_lat1", last_sa, 1'b0);
        check("flush_empty_lat3", last_sb, 1'b0);
        check("flush_count", cnt_b, 16'd0);

        // Async reset mid-stall with no clock edge.
        do_reset();
        step(LW8, 1'b1, 1'b0);
        step(ADD8, 1'b1, 1'b0);
        step(LW8, 1'b1, 1'b0);
        instruction_d = ADD8;
        valid_d       = 1'b1;
        flush         = 1'b0;
        #2;
        check("ar_pre_stall", stall_a, 1'b1);
        check("ar_pre_count", cnt_a, 16'd1);
        reset = 1'b0;
        #1;
        check("ar_stall", stall_a, 1'b0);
        check("ar_stall_lat3", stall_b, 1'b0);
        check("ar_count", cnt_a, 16'd0);
        check("ar_count_lat3", cnt_b, 16'd0);
        model_reset();
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b1;
        step(ADD8, 1'b1, 1'b0);
        check("ar_restart_empty", last_sb, 1'b0);

        // Saturation of the 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(LW8, 1'b1, 1'b0);
            step(ADD8, 1'b1, 1'b0);
        end
        step(32'h0, 1'b0, 1'b0);
        check("sat_count_cw2", cnt_c, 2'd3);
        check("sat_count_lat1", cnt_a, 16'd5);

        // Randomized stream against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rins = {ops[$urandom_range(0, 13)], 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 16'($urandom)};
            step(rins, $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Parametrised successor to the combinational load/store opcode detector. Decodes the decode-stage instruction: load/store class, access size, signedness.
- Tracks destination registers of loads in flight for LOAD_LATENCY cycles and raises a load-use stall when the decode-stage instruction reads one of them.
- Sits beside the decode stage of the 5-stage MIPS pipeline.
- Keeps a saturating stall-cycle counter for performance statistics.

Parameters:
- LOAD_LATENCY, 1, cycles after a load leaves D during which a dependent instruction must hold in D (1 = forwarding from W into E); legal 1..4
- REG_ADDR_WIDTH, 5, register index width
- COUNT_WIDTH, 16, width of stall_count

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- instruction_d  input  32  instruction currently in D
- valid_d  input  1  instruction_d is a real instruction (0 = bubble)
- flush  input  1  squash all in-flight tracking and the D instruction this cycle
- stall  output  1  hold D (and F) this cycle; E receives a bubble
- is_load  output  1  instruction_d is lb/lbu/lh/lhu/lw
- is_store  output  1  instruction_d is sb/sh/sw
- access_size  output  2  0 byte, 1 half, 2 word; 0 when neither load nor store
- access_unsigned  output  1  1 for lbu/lhu only
- stall_count  output  COUNT_WIDTH  saturating count of cycles with stall=1

Behaviour:
- Decode (combinational from instruction_d[31:26]; gated by valid_d):
  - Loads: 100000 lb, 100100 lbu, 100001 lh, 100101 lhu, 100011 lw.
  - Stores: 101000 sb, 101001 sh, 101011 sw.
  - Any other opcode: is_load = is_store = 0.
- Source usage:
  - use_rs = 1 except opcodes 000010 j, 000011 jal, 001111 lui.
  - use_rt = 1 for opcode 000000 (R-type), 000100 beq, 000101 bne, and all stores.
  - Register 0 never matches.
- Tracker: LOAD_LATENCY entries {v, dst[REG_ADDR_WIDTH-1:0]}, index 0 youngest. Shifts every cycle; the oldest entry is discarded.
- Entry 0 next value:
  - {1, rt} when valid_d & is_load & rt != 0 & ~stall & ~flush.
  - Otherwise {0, x}; a stall inserts a bubble.
- hazard = valid_d & OR over valid entries of ((use_rs & rs == dst) | (use_rt & rt == dst)).
- stall = hazard & ~flush (combinational). Flush overrides stall in the same cycle.
- flush = 1: all entries invalid at the next edge; the D instruction is not inserted.
- stall_count increments on each edge where stall = 1. It saturates at all-ones and never wraps.
- Reset (reset = 0, asynchronous):
  - All entries invalid; stall_count = 0.
  - Outputs while in reset: stall = 0. Decode outputs follow instruction_d & valid_d.
  - Reset mid-stall releases the stall immediately; tracking restarts empty.
- Latency: a load accepted at edge N blocks a dependent in D during cycles N..N+LOAD_LATENCY-1. At LOAD_LATENCY = 1 this is exactly one stall cycle.
- Back-to-back loads to the same register: each is tracked independently; the stall lasts until the youngest ages out.
- A load whose own rs matches a pending load stalls like any other consumer. A load stalled this way is not inserted until it is released.

Test Plan:
- Load then consumer: lw $8,0($9) (0x8D280000) accepted, then add $10,$8,$11 (0x010B5020) in D -> stall = 1 for exactly 1 cycle (LOAD_LATENCY = 1), stall_count = 1. Rerun with LOAD_LATENCY = 3 -> 3 stall cycles.
- Store data dependency: 0x8D280000 then sw $8,4($9) (0xAD280004) -> stall 1 cycle (rt match). is_store = 1, access_size = 2, access_unsigned = 0.
- No false hazards:
  - lw $0,0($9) (0x8D200000) then an add reading $0 -> stall = 0.
  - lui $8 (0x3C080001) after lw $8 -> stall = 0 (rs unused).
- Decode sweep: all 8 load/store opcodes plus 0x00000000 -> correct is_load, is_store, access_size, access_unsigned. Example: 0x91280000 lbu gives size 0, unsigned 1.
- Flush during stall: assert flush in the stalled cycle of the first test -> stall = 0 that cycle. The next cycle the consumer reads $8 with no stall; entries are empty.
- Async reset and saturation:
  - Pull reset low mid-stall without a clock edge -> stall = 0 and stall_count = 0 immediately.
  - With COUNT_WIDTH = 2, force 5 stall cycles -> stall_count holds 3.
